// File: rtl/cond_unit_if.sv
// Instruction-side bundle between decoder/ALU and the condition unit: condition, flags,
// write strobes in; gated strobes and architectural flag/counter state out.
interface cond_unit_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             instr_valid;
   logic [3:0]       cond;
   logic [3:0]       alu_flags;
   logic [1:0]       flag_write;
   logic             pcs_in;
   logic             reg_write_in;
   logic             mem_write_in;
   logic             no_write_in;
   logic             save_flags;
   logic             restore_flags;
   logic             clr_count;

   logic             cond_ex;
   logic             pcs_out;
   logic             reg_write_out;
   logic             mem_write_out;
   logic [3:0]       flags_q;
   logic [3:0]       saved_flags_q;
   logic [CNT_W-1:0] annul_count;

   modport master (
      output en, instr_valid, cond, alu_flags, flag_write,
             pcs_in, reg_write_in, mem_write_in, no_write_in,
             save_flags, restore_flags, clr_count,
      input  cond_ex, pcs_out, reg_write_out, mem_write_out,
             flags_q, saved_flags_q, annul_count
   );

   modport slave (
      input  en, instr_valid, cond, alu_flags, flag_write,
             pcs_in, reg_write_in, mem_write_in, no_write_in,
             save_flags, restore_flags, clr_count,
      output cond_ex, pcs_out, reg_write_out, mem_write_out,
             flags_q, saved_flags_q, annul_count
   );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register with shadow copy, condition evaluation,
// write-enable gating and a saturating count of annulled instructions.
module cond_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter int         CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   cond_unit_if.slave bus
);

   logic [3:0]       flags_q, flags_d;
   logic [3:0]       saved_q, saved_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       flags_upd;
   logic             pass;
   logic             cond_ex;
   logic             flag_n, flag_z, flag_c, flag_v;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Evaluated against the registered flags only; same-cycle ALU flags never feed back.
   always_comb begin
      pass = 1'b0;
      unique case (bus.cond)
         4'b0000: pass = flag_z;
         4'b0001: pass = ~flag_z;
         4'b0010: pass = flag_c;
         4'b0011: pass = ~flag_c;
         4'b0100: pass = flag_n;
         4'b0101: pass = ~flag_n;
         4'b0110: pass = flag_v;
         4'b0111: pass = ~flag_v;
         4'b1000: pass = flag_c & ~flag_z;
         4'b1001: pass = ~flag_c | flag_z;
         4'b1010: pass = (flag_n == flag_v);
         4'b1011: pass = (flag_n != flag_v);
         4'b1100: pass = ~flag_z & (flag_n == flag_v);
         4'b1101: pass = flag_z | (flag_n != flag_v);
         default: pass = 1'b1;
      endcase
   end

   assign cond_ex           = pass & bus.instr_valid;
   assign bus.cond_ex       = cond_ex;
   assign bus.pcs_out       = bus.pcs_in & cond_ex;
   assign bus.reg_write_out = bus.reg_write_in & cond_ex & ~bus.no_write_in;
   assign bus.mem_write_out = bus.mem_write_in & cond_ex;

   // flag_write[1] owns N,Z and flag_write[0] owns C,V; unselected pairs hold.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_field
         assign flags_upd[2*gi+1 -: 2] = (cond_ex && bus.flag_write[gi])
                                         ? bus.alu_flags[2*gi+1 -: 2]
                                         : flags_q[2*gi+1 -: 2];
      end
   endgenerate

   always_comb begin
      flags_d = bus.restore_flags ? saved_q : flags_upd;
      saved_d = (bus.save_flags && !bus.restore_flags) ? flags_q : saved_q;
      cnt_d   = cnt_q;
      if (bus.clr_count) begin
         cnt_d = '0;
      end else if (bus.instr_valid && !pass && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= RESET_FLAGS;
         saved_q <= RESET_FLAGS;
         cnt_q   <= '0;
      end else if (bus.en) begin
         flags_q <= flags_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.flags_q       = flags_q;
   assign bus.saved_flags_q = saved_q;
   assign bus.annul_count   = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: a 16-bit-counter instance for flag behaviour and a
// 4-bit-counter instance for saturation.
module tb_cond_unit;

   logic clk;
   logic rst_n;
   int   total_cnt;
   int   pass_cnt;

   cond_unit_if #(.CNT_W(16)) a_if ();
   cond_unit_if #(.CNT_W(4))  b_if ();

   cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(16)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_if.instr_valid   = 1'b0;
      a_if.cond          = 4'b1110;
      a_if.alu_flags     = 4'b0000;
      a_if.flag_write    = 2'b00;
      a_if.pcs_in        = 1'b0;
      a_if.reg_write_in  = 1'b0;
      a_if.mem_write_in  = 1'b0;
      a_if.no_write_in   = 1'b0;
      a_if.save_flags    = 1'b0;
      a_if.restore_flags = 1'b0;
      a_if.clr_count     = 1'b0;
   endtask

   // Expected pass bit per cond code with flags N=0 Z=1 C=1 V=0.
   logic [15:0] exp_0110;

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;
      exp_0110  = 16'b1110_0110_1010_0101;
      rst_n     = 1'b0;
      a_if.en   = 1'b1;
      idle_a();
      a_if.instr_valid = 1'b1;
      a_if.cond        = 4'b0000;
      b_if.en            = 1'b1;
      b_if.instr_valid   = 1'b0;
      b_if.cond          = 4'b0000;
      b_if.alu_flags     = 4'b0000;
      b_if.flag_write    = 2'b00;
      b_if.pcs_in        = 1'b0;
      b_if.reg_write_in  = 1'b0;
      b_if.mem_write_in  = 1'b0;
      b_if.no_write_in   = 1'b0;
      b_if.save_flags    = 1'b0;
      b_if.restore_flags = 1'b0;
      b_if.clr_count     = 1'b0;

      #12;
      chk("reset_cond_ex", a_if.cond_ex, 1'b0);
      chk("reset_flags", a_if.flags_q, 4'b0000);
      chk("reset_saved", a_if.saved_flags_q, 4'b0000);
      chk("reset_count", a_if.annul_count, 16'd0);
      a_if.instr_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // CMP-style instruction
      a_if.instr_valid  = 1'b1;
      a_if.cond         = 4'b1110;
      a_if.alu_flags    = 4'b0110;
      a_if.flag_write   = 2'b11;
      a_if.no_write_in  = 1'b1;
      a_if.reg_write_in = 1'b1;
      #1;
      chk("cmp_cond_ex", a_if.cond_ex, 1'b1);
      chk("cmp_reg_write_out", a_if.reg_write_out, 1'b0);
      step();
      chk("cmp_flags", a_if.flags_q, 4'b0110);

      a_if.flag_write  = 2'b00;
      a_if.no_write_in = 1'b0;
      a_if.cond        = 4'b0000;
      #1;
      chk("eq_cond_ex", a_if.cond_ex, 1'b1);
      chk("eq_reg_write_out", a_if.reg_write_out, 1'b1);
      a_if.cond = 4'b1011;
      #1;
      chk("lt_cond_ex", a_if.cond_ex, 1'b0);
      chk("lt_reg_write_out", a_if.reg_write_out, 1'b0);

      for (int c = 0; c < 16; c++) begin
         a_if.cond = 4'(c);
         #1;
         chk($sformatf("cond_table_%0d", c), a_if.cond_ex, exp_0110[c]);
      end

      // N,Z only update
      a_if.cond       = 4'b1110;
      a_if.flag_write = 2'b10;
      a_if.alu_flags  = 4'b1001;
      step();
      chk("partial_flags", a_if.flags_q, 4'b1010);

      // Failed condition: EQ with Z=0
      a_if.cond         = 4'b0000;
      a_if.flag_write   = 2'b11;
      a_if.alu_flags    = 4'b1111;
      a_if.pcs_in       = 1'b1;
      a_if.mem_write_in = 1'b1;
      a_if.reg_write_in = 1'b1;
      #1;
      chk("fail_cond_ex", a_if.cond_ex, 1'b0);
      chk("fail_pcs_out", a_if.pcs_out, 1'b0);
      chk("fail_reg_write_out", a_if.reg_write_out, 1'b0);
      chk("fail_mem_write_out", a_if.mem_write_out, 1'b0);
      step();
      chk("fail_flags_hold", a_if.flags_q, 4'b1010);
      chk("fail_count", a_if.annul_count, 16'd1);
      a_if.instr_valid = 1'b0;
      step();
      chk("bubble_count", a_if.annul_count, 16'd1);
      chk("bubble_flags", a_if.flags_q, 4'b1010);
      a_if.cond = 4'b1110;
      #1;
      chk("bubble_cond_ex", a_if.cond_ex, 1'b0);
      chk("bubble_pcs_out", a_if.pcs_out, 1'b0);
      chk("bubble_mem_write_out", a_if.mem_write_out, 1'b0);

      // Save/restore
      idle_a();
      a_if.instr_valid = 1'b1;
      a_if.flag_write  = 2'b01;
      a_if.alu_flags   = 4'b0000;
      step();
      chk("pre_save_flags", a_if.flags_q, 4'b1000);
      a_if.flag_write = 2'b00;
      a_if.save_flags = 1'b1;
      step();
      chk("save_saved", a_if.saved_flags_q, 4'b1000);
      a_if.save_flags = 1'b0;
      a_if.flag_write = 2'b11;
      a_if.alu_flags  = 4'b0100;
      step();
      chk("post_save_update", a_if.flags_q, 4'b0100);
      a_if.restore_flags = 1'b1;
      a_if.alu_flags     = 4'b1111;
      step();
      chk("restore_overrides", a_if.flags_q, 4'b1000);
      a_if.restore_flags = 1'b0;
      a_if.alu_flags     = 4'b0010;
      step();
      chk("pre_both_flags", a_if.flags_q, 4'b0010);
      a_if.flag_write    = 2'b00;
      a_if.save_flags    = 1'b1;
      a_if.restore_flags = 1'b1;
      step();
      chk("both_saved_hold", a_if.saved_flags_q, 4'b1000);
      chk("both_restored", a_if.flags_q, 4'b1000);

      // Stall freezes everything
      idle_a();
      a_if.en          = 1'b0;
      a_if.instr_valid = 1'b1;
      a_if.cond        = 4'b0000;
      a_if.flag_write  = 2'b11;
      a_if.alu_flags   = 4'b1111;
      a_if.clr_count   = 1'b1;
      a_if.save_flags  = 1'b1;
      step();
      chk("stall_flags", a_if.flags_q, 4'b1000);
      chk("stall_saved", a_if.saved_flags_q, 4'b1000);
      chk("stall_count", a_if.annul_count, 16'd1);
      a_if.cond = 4'b1110;
      #1;
      chk("stall_cond_ex_driven", a_if.cond_ex, 1'b1);

      idle_a();
      a_if.en        = 1'b1;
      a_if.clr_count = 1'b1;
      step();
      chk("clr_count", a_if.annul_count, 16'd0);

      // Asynchronous reset mid-stream
      a_if.clr_count   = 1'b0;
      a_if.instr_valid = 1'b1;
      a_if.cond        = 4'b0000;
      step();
      chk("pre_reset_count", a_if.annul_count, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_flags", a_if.flags_q, 4'b0000);
      chk("midreset_saved", a_if.saved_flags_q, 4'b0000);
      chk("midreset_count", a_if.annul_count, 16'd0);
      idle_a();
      step();
      rst_n = 1'b1;
      step();

      // 4-bit counter saturation
      b_if.instr_valid = 1'b1;
      b_if.cond        = 4'b0000;
      for (int i = 0; i < 16; i++) step();
      chk("sat_reach", b_if.annul_count, 4'hF);
      step();
      step();
      chk("sat_hold", b_if.annul_count, 4'hF);
      b_if.clr_count = 1'b1;
      step();
      chk("sat_clr", b_if.annul_count, 4'h0);
      b_if.clr_count = 1'b0;
      step();
      step();
      chk("cnt_two", b_if.annul_count, 4'h2);
      b_if.en = 1'b0;
      step();
      step();
      step();
      chk("cnt_frozen", b_if.annul_count, 4'h2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
